// File: rtl/controlador_pi_pkg.sv
// Shared constants for the controlador_pi PI controller.
//   N        word width of setpoint, measurement, gains, error, integrator, output
//   F        fractional bits of the kp/ki gains (Q(N-F).F)
//   MAX/MIN  symmetric clip limits of an N-bit signed word
//   state_t  FSM encoding of the sequencer in controlador_pi
package controlador_pi_pkg;

  localparam int N = 18;
  localparam int F = 8;

  localparam logic signed [N-1:0] MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    MULP = 3'd2,
    MULI = 3'd3,
    SUM  = 3'd4
  } state_t;

endpackage

// File: rtl/controlador_pi_mult_q_sat.sv
// mult_q_sat: combinational signed N x N multiply, arithmetic shift right by F
// (floor toward -inf), then clip to the N-bit range [MIN, MAX].
// Ports:
//   a, b  in  N  signed operands (one Q(N-F).F gain, one integer-scaled value)
//   q     out N  saturated, integer-scaled product
module mult_q_sat
  import controlador_pi_pkg::*;
(
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] q
);

  localparam logic signed [2*N-1:0] MAX_W = MAX;
  localparam logic signed [2*N-1:0] MIN_W = MIN;

  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] shifted;

  function automatic logic signed [N-1:0] sat_2n(input logic signed [2*N-1:0] v);
    if (v > MAX_W)      return MAX;
    else if (v < MIN_W) return MIN;
    else                return v[N-1:0];
  endfunction

  assign prod    = a * b;
  assign shifted = prod >>> F;
  assign q       = sat_2n(shifted);

endmodule

// File: rtl/controlador_pi.sv
// controlador_pi: discrete PI controller, u = Kp*e + Ki*sum(e), one update per
// start tick, sequenced IDLE -> ERR -> MULP -> MULI -> SUM -> IDLE over a single
// shared multiply/shift/saturate datapath.
// Optional build macro CONTROLADOR_PI_ANTIWINDUP_EN: conditional-integration
// anti-windup (the integrator holds while the output is clipped and the error
// pushes further in the same direction).
// Ports:
//   clk       in  1  system clock
//   reset     in  1  synchronous, active-high reset
//   start     in  1  sample tick, accepted only in IDLE
//   setpoint  in  N  signed reference (named setpoint because 'ref' is a keyword)
//   y         in  N  signed plant measurement
//   kp, ki    in  N  signed gains, Q(N-F).F
//   u         out N  signed controller output, registered
//   done      out 1  one-cycle pulse when u has been updated
//   busy      out 1  high while the FSM is not in IDLE
module controlador_pi
  import controlador_pi_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [N-1:0] setpoint,
  input  logic signed [N-1:0] y,
  input  logic signed [N-1:0] kp,
  input  logic signed [N-1:0] ki,
  output logic signed [N-1:0] u,
  output logic                done,
  output logic                busy
);

  localparam logic signed [N:0] MAX_W = MAX;
  localparam logic signed [N:0] MIN_W = MIN;

  state_t              state;
  logic signed [N-1:0] sp_r, y_r, kp_r, ki_r;
  logic signed [N-1:0] e, acc, p, i_term;
  logic signed [N:0]   diff, acc_sum, out_sum;
  logic signed [N-1:0] e_next;
  logic signed [N-1:0] mul_a, mul_b, mul_q;
  logic                hold_acc;

  function automatic logic signed [N-1:0] sat_n1(input logic signed [N:0] v);
    if (v > MAX_W)      return MAX;
    else if (v < MIN_W) return MIN;
    else                return v[N-1:0];
  endfunction

  function automatic logic clipped(input logic signed [N:0] v);
    return (v > MAX_W) || (v < MIN_W);
  endfunction

  // All sums are formed one bit wider than the operands so clipping never wraps.
  assign diff    = {sp_r[N-1], sp_r} - {y_r[N-1], y_r};
  assign e_next  = sat_n1(diff);
  assign acc_sum = {acc[N-1], acc} + {e_next[N-1], e_next};
  assign out_sum = {p[N-1], p} + {i_term[N-1], i_term};

  // Shared multiplier: proportional operands in MULP, integral operands in MULI.
  assign mul_a = (state == MULI) ? ki_r : kp_r;
  assign mul_b = (state == MULI) ? acc  : e;

  mult_q_sat u_mult (
    .a (mul_a),
    .b (mul_b),
    .q (mul_q)
  );

`ifdef CONTROLADOR_PI_ANTIWINDUP_EN
  logic sat_flag;
  // Integrating further in the direction the output is already clipped only winds up.
  assign hold_acc = sat_flag && (e_next != '0) && (e_next[N-1] == u[N-1]);
`else
  assign hold_acc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      u     <= '0;
      acc   <= '0;
`ifdef CONTROLADOR_PI_ANTIWINDUP_EN
      sat_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= ERR;
          end
        end
        ERR: begin
          if (!hold_acc) acc <= sat_n1(acc_sum);
          state <= MULP;
        end
        MULP: state <= MULI;
        MULI: state <= SUM;
        SUM: begin
          u     <= sat_n1(out_sum);
`ifdef CONTROLADOR_PI_ANTIWINDUP_EN
          sat_flag <= clipped(out_sum);
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Operand capture and intermediate terms carry no reset; each is written before use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          sp_r <= setpoint;
          y_r  <= y;
          kp_r <= kp;
          ki_r <= ki;
        end
      end
      ERR:     e      <= e_next;
      MULP:    p      <= mul_q;
      MULI:    i_term <= mul_q;
      default: ;
    endcase
  end

`ifndef CONTROLADOR_PI_ANTIWINDUP_EN
  logic unused_clip;
  assign unused_clip = clipped(out_sum);
`endif

endmodule

// File: tb/tb_controlador_pi.sv
// Self-checking bench for controlador_pi: directed scenarios from the test plan
// plus randomized samples, checked against an arithmetic model of the PI law.
module tb_controlador_pi;

  localparam int     N    = 18;
  localparam longint MAXV = 131071;
  localparam longint MINV = -131072;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic signed [N-1:0] setpoint, y, kp, ki;
  logic signed [N-1:0] u;
  logic                done, busy;

  int n_cmp = 0;
  int n_bad = 0;

  longint m_acc, m_u;
  bit     m_sat;

  controlador_pi dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .setpoint (setpoint),
    .y        (y),
    .kp       (kp),
    .ki       (ki),
    .u        (u),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic longint clip(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Floor division by 2^8, the gain scale.
  function automatic longint fdiv(input longint a);
    longint q;
    q = a / 256;
    if ((a % 256) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_u   = 0;
    m_sat = 0;
  endtask

  task automatic model_step(input longint r, input longint yy, input longint pk,
                            input longint ik, output longint eu);
    longint e, p, i, s;
    bit integrate;
    e = clip(r - yy);
    integrate = 1;
`ifdef CONTROLADOR_PI_ANTIWINDUP_EN
    if (m_sat && e != 0 && ((e < 0) == (m_u < 0))) integrate = 0;
`endif
    if (integrate) m_acc = clip(m_acc + e);
    p = clip(fdiv(pk * e));
    i = clip(fdiv(ik * m_acc));
    s = p + i;
    m_u = clip(s);
    m_sat = (s != m_u);
    eu = m_u;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_inputs(input longint r, input longint yy, input longint pk, input longint ik);
    setpoint = r[N-1:0];
    y        = yy[N-1:0];
    kp       = pk[N-1:0];
    ki       = ik[N-1:0];
  endtask

  // One start pulse; inputs are scrambled right after capture. lat counts edges
  // after the capturing edge until done is seen (-1 on timeout).
  task automatic run_sample(input longint r, input longint yy, input longint pk, input longint ik,
                            output longint got, output int lat, output logic [7:0] bh);
    @(negedge clk);
    drive_inputs(r, yy, pk, ik);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    setpoint = N'($urandom);
    y        = N'($urandom);
    kp       = N'($urandom);
    ki       = N'($urandom);
    bh       = '0;
    bh[0]    = busy;
    lat      = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 8) bh[k] = busy;
      if (done) begin
        lat = k;
        break;
      end
    end
    got = u;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    drive_inputs(100, 0, 256, 256);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (u !== '0)   begin n_bad++; $display("FAIL reset_u got=%0d want=0", u); end
    n_cmp++; if (done !== 0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (busy !== 0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b0;
    start = 1'b0;
    model_reset();
  endtask

  task automatic test_proportional();
    longint got, exp_u; int lat; logic [7:0] bh;
    apply_reset();
    model_step(100, 40, 256, 0, exp_u);
    run_sample(100, 40, 256, 0, got, lat, bh);
    n_cmp++; if (got !== 60) begin n_bad++; $display("FAIL prop_u got=%0d want=60", got); end
    n_cmp++; if (got !== exp_u) begin n_bad++; $display("FAIL prop_model got=%0d want=%0d", got, exp_u); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL prop_latency got=%0d want=4", lat); end
    n_cmp++; if (bh[4:0] !== 5'b01111) begin n_bad++; $display("FAIL prop_busy got=%b want=01111", bh[4:0]); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL prop_done_pulse got=%b want=0", done); end
    n_cmp++; if (u !== 18'sd60) begin n_bad++; $display("FAIL prop_u_hold got=%0d want=60", u); end
  endtask

  task automatic test_integral();
    longint got, exp_u; int lat; logic [7:0] bh;
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      model_step(10, 0, 0, 256, exp_u);
      run_sample(10, 0, 0, 256, got, lat, bh);
      n_cmp++; if (got !== 10 * (s + 1)) begin n_bad++; $display("FAIL integ_u[%0d] got=%0d want=%0d", s, got, 10 * (s + 1)); end
      n_cmp++; if (got !== exp_u) begin n_bad++; $display("FAIL integ_model[%0d] got=%0d want=%0d", s, got, exp_u); end
    end
  endtask

  task automatic test_fractional();
    longint got, exp_u; int lat; logic [7:0] bh;
    apply_reset();
    model_step(-50, 50, 128, 0, exp_u);
    run_sample(-50, 50, 128, 0, got, lat, bh);
    n_cmp++; if (got !== -50) begin n_bad++; $display("FAIL frac_half got=%0d want=-50", got); end
    model_step(-51, 0, 128, 0, exp_u);
    run_sample(-51, 0, 128, 0, got, lat, bh);
    n_cmp++; if (got !== -26) begin n_bad++; $display("FAIL frac_floor got=%0d want=-26", got); end
    n_cmp++; if (got !== exp_u) begin n_bad++; $display("FAIL frac_model got=%0d want=%0d", got, exp_u); end
  endtask

  task automatic test_saturation();
    longint got, exp_u; int lat; logic [7:0] bh;
    apply_reset();
    model_step(MAXV, MINV, 512, 0, exp_u);
    run_sample(MAXV, MINV, 512, 0, got, lat, bh);
    n_cmp++; if (got !== MAXV) begin n_bad++; $display("FAIL sat_pos got=%0d want=%0d", got, MAXV); end
    model_step(MINV, MAXV, 512, 0, exp_u);
    run_sample(MINV, MAXV, 512, 0, got, lat, bh);
    n_cmp++; if (got !== MINV) begin n_bad++; $display("FAIL sat_neg got=%0d want=%0d", got, MINV); end
    n_cmp++; if (got !== exp_u) begin n_bad++; $display("FAIL sat_model got=%0d want=%0d", got, exp_u); end
  endtask

  task automatic test_ignore_start();
    longint exp_u; int dones;
    apply_reset();
    model_step(30, 10, 256, 0, exp_u);
    @(negedge clk);
    drive_inputs(30, 10, 256, 0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_inputs(999, 0, 256, 256);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
    n_cmp++; if (u !== exp_u[N-1:0]) begin n_bad++; $display("FAIL ignore_u got=%0d want=%0d", u, exp_u); end
  endtask

  task automatic test_reset_mid();
    longint got, exp_u; int lat, dones; logic [7:0] bh;
    apply_reset();
    run_sample(50, 0, 256, 256, got, lat, bh);
    @(negedge clk);
    drive_inputs(40, 0, 256, 256);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rstmid_done got=%0d want=0", dones); end
    n_cmp++; if (u !== '0) begin n_bad++; $display("FAIL rstmid_u got=%0d want=0", u); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    model_step(7, 0, 0, 256, exp_u);
    run_sample(7, 0, 0, 256, got, lat, bh);
    n_cmp++; if (got !== 7) begin n_bad++; $display("FAIL rstmid_fresh got=%0d want=7", got); end
  endtask

  task automatic test_back_to_back();
    longint exp_u[3]; int done_k[$]; int idx;
    apply_reset();
    for (int s = 0; s < 3; s++) model_step(20, 5, 256, 128, exp_u[s]);
    @(negedge clk);
    drive_inputs(20, 5, 256, 128);
    start = 1'b1;
    @(posedge clk);
    idx = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 14) start = 1'b0;
      if (done) begin
        done_k.push_back(k);
        if (idx < 3) begin
          n_cmp++; if (u !== exp_u[idx][N-1:0]) begin n_bad++; $display("FAIL b2b_u[%0d] got=%0d want=%0d", idx, u, exp_u[idx]); end
        end
        idx++;
      end
    end
    n_cmp++; if (done_k.size() !== 3) begin n_bad++; $display("FAIL b2b_count got=%0d want=3", done_k.size()); end
    for (int s = 0; s < 3 && s < done_k.size(); s++) begin
      n_cmp++; if (done_k[s] !== 4 + 5 * s) begin n_bad++; $display("FAIL b2b_edge[%0d] got=%0d want=%0d", s, done_k[s], 4 + 5 * s); end
    end
  endtask

  task automatic test_antiwindup();
    longint got, exp_u, acc_dut; int lat; logic [7:0] bh;
    logic signed [N-1:0] a;
    apply_reset();
    for (int s = 0; s < 5; s++) begin
      model_step(MAXV, 0, 512, 256, exp_u);
      run_sample(MAXV, 0, 512, 256, got, lat, bh);
      n_cmp++; if (got !== MAXV) begin n_bad++; $display("FAIL aw_u[%0d] got=%0d want=%0d", s, got, MAXV); end
    end
    a = dut.acc; acc_dut = a;
    n_cmp++; if (acc_dut !== MAXV) begin n_bad++; $display("FAIL aw_acc_sat got=%0d want=%0d", acc_dut, MAXV); end
    // Clipped by the proportional term alone while the integrator is still small.
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      model_step(1000, 0, 65536, 1, exp_u);
      run_sample(1000, 0, 65536, 1, got, lat, bh);
      n_cmp++; if (got !== exp_u) begin n_bad++; $display("FAIL aw_small_u[%0d] got=%0d want=%0d", s, got, exp_u); end
    end
    a = dut.acc; acc_dut = a;
    n_cmp++; if (acc_dut !== m_acc) begin n_bad++; $display("FAIL aw_acc_hold got=%0d want=%0d", acc_dut, m_acc); end
  endtask

  task automatic test_random();
    longint got, exp_u, r, yy, pk, ik; int lat; logic [7:0] bh;
    logic signed [N-1:0] t;
    apply_reset();
    for (int s = 0; s < 40; s++) begin
      t = N'($urandom); r = t;
      t = N'($urandom); yy = t;
      if (s % 4 == 0) begin
        t = N'($urandom); pk = t;
        t = N'($urandom); ik = t;
      end else begin
        pk = longint'($urandom_range(0, 4096)) - 2048;
        ik = longint'($urandom_range(0, 512)) - 256;
      end
      model_step(r, yy, pk, ik, exp_u);
      run_sample(r, yy, pk, ik, got, lat, bh);
      n_cmp++; if (got !== exp_u) begin n_bad++; $display("FAIL rand_u[%0d] got=%0d want=%0d", s, got, exp_u); end
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rand_latency[%0d] got=%0d want=4", s, lat); end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    drive_inputs(0, 0, 0, 0);
    model_reset();
    test_reset();
    test_proportional();
    test_integral();
    test_fractional();
    test_saturation();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_antiwindup();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/controlador_pi.md
Name: controlador_pi

Overview:
- Discrete PI controller stage directly downstream of the switch-driven reference register.
- Consumes the signed N-bit setpoint `ref` and a plant measurement `y`.
- Computes error e = ref − y, a saturating integrator, and the output u = Kp·e + Ki·Σe in signed fixed point.
- One shared multiply/shift/saturate datapath, sequenced by a small FSM with a start/done handshake, one update per sample tick.

Parameters:
- N, 18, word width; matches the system-wide `N` (signed two's complement).
- F, 8, fractional bits of kp/ki (Q(N−F).F gains); ref, y, e, acc and u are integer-scaled.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  sample tick; accepted only in IDLE
- ref  in  N  signed setpoint (from reference register)
- y  in  N  signed plant measurement
- kp  in  N  signed proportional gain, Q(N−F).F
- ki  in  N  signed integral gain, Q(N−F).F
- u  out  N  signed controller output, registered
- done  out  1  one-cycle pulse, u updated
- busy  out  1  high while FSM not in IDLE

Behaviour:
- Reset (synchronous to clk, active-high; it takes effect on a rising clk edge while reset=1):
  - Clears u=0, done=0, busy=0, acc=0, sat_flag=0, and sets the state to IDLE.
  - Reset overrides start.
- FSM states: IDLE → ERR → MULP → MULI → SUM → IDLE.
  - IDLE: on start=1, capture ref, y, kp, ki into input registers, set busy=1, go to ERR.
  - ERR:
    - e = sat(ref − y), computed in N+1 bits then saturated to [MIN, MAX], with MIN = −2^(N−1) and MAX = 2^(N−1)−1.
    - acc ← sat(acc + e), also computed in N+1 bits.
  - MULP: p ← sat((kp·e) >>> F). Product is 2N bits; the arithmetic shift truncates toward −∞.
  - MULI: i ← sat((ki·acc) >>> F), using the acc value updated in ERR.
  - SUM:
    - u ← sat(p + i); sat_flag ← 1 if clipping occurred, else 0.
    - done=1 for exactly this one cycle; busy falls when the FSM returns to IDLE.
- Latency: start sampled at edge t → u valid and done=1 during the cycle after edge t+4. Maximum throughput is one sample per 5 cycles.
- start while busy=1 is ignored (not queued); start held high re-triggers on the first IDLE cycle.
- Input changes after capture do not affect the current computation.
- u holds its value between updates; done is never high in IDLE except as the SUM→IDLE pulse.
- Reset mid-computation: FSM aborts, no done pulse, acc cleared.
- All saturation is symmetric-clip to [MIN, MAX]; there is no wrap-around anywhere.

Optional Feature:
- Macro: CONTROLADOR_PI_ANTIWINDUP_EN.
- Defined: in ERR, the acc update is skipped when sat_flag=1 and e has the same sign as the last u (e≠0). This is conditional-integration anti-windup.
- Undefined: acc always updates (saturating only); sat_flag logic may be omitted.

Decomposition:
- Shared constants file/package:
  - N, F
  - MAX/MIN limits
  - FSM state encodings (IDLE=0, ERR=1, MULP=2, MULI=3, SUM=4, 3 bits)
- Sub-module `mult_q_sat`: combinational signed N×N multiply, arithmetic shift by F, saturate to N bits; instantiated once and muxed between the MULP/MULI operands.

Test Plan:
- Proportional: kp=256 (1.0), ki=0, ref=100, y=40, start → done at t+4 with u=60; busy high for cycles t+1..t+4.
- Integral: kp=0, ki=256, ref=10, y=0, three starts spaced 6 cycles apart → u=10, 20, 30.
- Fractional/negative: kp=128 (0.5), ki=0, ref=−50, y=50 → e=−100, u=−50. With ref=−51, y=0 → u=−26 (floor of −25.5).
- Saturation: kp=512, ki=0, ref=131071, y=−131072 → e clips to 131071, u=131071. Mirror case → u=−131072.
- Handshake/reset:
  - start pulsed again at t+2 → ignored, exactly one done.
  - reset at t+2 → no done; u=0, acc=0; the next start gives a fresh result.
- Anti-windup (macro defined): kp=512, ki=256, ref=131071, y=0, 5 starts → u=131071 and acc stops at its first saturated value. Without the macro, acc keeps growing to 131071.
